// File: rtl/frame_scan_reader_pkg.sv
// Shared constants and types for the Laplacian result frame and its VGA scan-out.
// Image geometry, VGA 640x480 timing, window placement and the 24-bit pixel type.
package frame_scan_reader_pkg;

  localparam int IMG_W  = 250;
  localparam int IMG_H  = 114;
  localparam int ADDR_W = 15;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int X_OFF = 195;
  localparam int Y_OFF = 183;

  typedef logic [23:0] pixel_t;

  localparam pixel_t BORDER = 24'h000000;

  typedef enum logic {
    SCAN_IDLE,
    SCAN_RUN
  } scan_state_t;

  // Stage-t video flags, all active-high so a cleared pipeline means "idle".
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic win;
    logic sof;
  } vid_flags_t;

endpackage

// File: rtl/frame_scan_reader_video_timing.sv
// VGA h/v counters with frame-boundary enable control; raw flags at stage t (0 cycles).
// No backpressure: free-running once enabled, en only sampled when idle or at the frame wrap.
module video_timing
  import frame_scan_reader_pkg::*;
#(
  parameter int IMG_W    = frame_scan_reader_pkg::IMG_W,
  parameter int IMG_H    = frame_scan_reader_pkg::IMG_H,
  parameter int H_ACTIVE = frame_scan_reader_pkg::H_ACTIVE,
  parameter int H_FP     = frame_scan_reader_pkg::H_FP,
  parameter int H_SYNC   = frame_scan_reader_pkg::H_SYNC,
  parameter int H_BP     = frame_scan_reader_pkg::H_BP,
  parameter int V_ACTIVE = frame_scan_reader_pkg::V_ACTIVE,
  parameter int V_FP     = frame_scan_reader_pkg::V_FP,
  parameter int V_SYNC   = frame_scan_reader_pkg::V_SYNC,
  parameter int V_BP     = frame_scan_reader_pkg::V_BP,
  parameter int X_OFF    = frame_scan_reader_pkg::X_OFF,
  parameter int Y_OFF    = frame_scan_reader_pkg::Y_OFF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  output vid_flags_t flags,
  output logic       line_last,
  output logic       frame_top
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] X_BEG   = HW'(X_OFF);
  localparam logic [HW-1:0] X_END   = HW'(X_OFF + IMG_W);
  localparam logic [HW-1:0] X_LAST  = HW'(X_OFF + IMG_W - 1);

  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] Y_BEG   = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_END   = VW'(Y_OFF + IMG_H);

  scan_state_t   state, state_nxt;
  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic          run;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= SCAN_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      v     <= v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    case (state)
      SCAN_IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (en) state_nxt = SCAN_RUN;
      end
      SCAN_RUN: begin
        if (h == H_LAST) begin
          h_nxt = '0;
          if (v == V_LAST) begin
            v_nxt = '0;
            // The only point where a running scan looks at en.
            if (!en) state_nxt = SCAN_IDLE;
          end else begin
            v_nxt = v + 1'b1;
          end
        end else begin
          h_nxt = h + 1'b1;
        end
      end
      default: state_nxt = SCAN_IDLE;
    endcase
  end

  assign run = (state == SCAN_RUN);

  always_comb begin
    flags     = '0;
    flags.act = run && (h < H_ACT_C) && (v < V_ACT_C);
    flags.hs  = run && (h >= HS_BEG) && (h < HS_END);
    flags.vs  = run && (v >= VS_BEG) && (v < VS_END);
    flags.win = run && (h >= X_BEG) && (h < X_END) && (v >= Y_BEG) && (v < Y_END);
    flags.sof = run && (h == '0) && (v == '0);
  end

  assign line_last = flags.win && (h == X_LAST);
  assign frame_top = run && (v == '0);

endmodule

// File: rtl/frame_scan_reader.sv
// Raster scan-out of the result frame into a VGA window; 3-cycle latency counters->outputs.
// No backpressure: one pixel per clock while scanning, en honoured only at frame boundaries.
module frame_scan_reader
  import frame_scan_reader_pkg::*;
#(
  parameter int     IMG_W    = frame_scan_reader_pkg::IMG_W,
  parameter int     IMG_H    = frame_scan_reader_pkg::IMG_H,
  parameter int     ADDR_W   = frame_scan_reader_pkg::ADDR_W,
  parameter int     H_ACTIVE = frame_scan_reader_pkg::H_ACTIVE,
  parameter int     H_FP     = frame_scan_reader_pkg::H_FP,
  parameter int     H_SYNC   = frame_scan_reader_pkg::H_SYNC,
  parameter int     H_BP     = frame_scan_reader_pkg::H_BP,
  parameter int     V_ACTIVE = frame_scan_reader_pkg::V_ACTIVE,
  parameter int     V_FP     = frame_scan_reader_pkg::V_FP,
  parameter int     V_SYNC   = frame_scan_reader_pkg::V_SYNC,
  parameter int     V_BP     = frame_scan_reader_pkg::V_BP,
  parameter int     X_OFF    = frame_scan_reader_pkg::X_OFF,
  parameter int     Y_OFF    = frame_scan_reader_pkg::Y_OFF,
  parameter pixel_t BORDER   = frame_scan_reader_pkg::BORDER
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  output logic [ADDR_W-1:0] rd_addr,
  input  pixel_t            rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output pixel_t            rgb,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  vid_flags_t        flags_t0, flags_t1, flags_t2;
  logic              line_last;
  logic              frame_top;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] col;

  video_timing #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .X_OFF   (X_OFF),
    .Y_OFF   (Y_OFF)
  ) u_timing (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .flags    (flags_t0),
    .line_last(line_last),
    .frame_top(frame_top)
  );

  // Incremental address: base steps by one line per window row, col counts across it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_base <= '0;
      col       <= '0;
      rd_addr   <= '0;
    end else if (flags_t0.win) begin
      rd_addr <= line_base + col;
      if (line_last) begin
        col       <= '0;
        line_base <= line_base + LINE_STEP;
      end else begin
        col <= col + 1'b1;
      end
    end else if (frame_top) begin
      line_base <= '0;
      col       <= '0;
    end
  end

  // Flags ride alongside the memory read so they meet rd_data at stage t+2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flags_t1    <= '0;
      flags_t2    <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      flags_t1    <= flags_t0;
      flags_t2    <= flags_t1;
      hsync       <= !flags_t2.hs;
      vsync       <= !flags_t2.vs;
      de          <= flags_t2.act;
      frame_start <= flags_t2.sof;
      if (flags_t2.win)      rgb <= rd_data;
      else if (flags_t2.act) rgb <= BORDER;
      else                   rgb <= '0;
    end
  end

endmodule

// File: tb/tb_frame_scan_reader.sv
// Bench for frame_scan_reader on a shrunken raster so several whole frames fit in a short run.
// A position-indexed model predicts every output each cycle; literal pins anchor key points.
module tb_frame_scan_reader;

  localparam int TW = 25, TH = 11, TXO = 20, TYO = 15;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] TBORDER = 24'h123456;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [14:0] rd_addr;
  logic [23:0] rd_data = '0;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;

  frame_scan_reader #(
    .IMG_W(TW), .IMG_H(TH), .ADDR_W(15),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X_OFF(TXO), .Y_OFF(TYO), .BORDER(TBORDER)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered result memory whose contents equal the address.
  always @(posedge clk) rd_data <= {9'd0, rd_addr};

  int checks = 0;
  int fails  = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit in_win(input bit run, input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    return run && h >= TXO && h < TXO + TW && v >= TYO && v < TYO + TH;
  endfunction

  function automatic int win_addr(input int p);
    return (p / HT - TYO) * TW + (p % HT - TXO);
  endfunction

  // Model: scan position as a linear pixel index, plus a 3-deep history of it.
  bit cur_run = 0, run1 = 0, run2 = 0, run3 = 0;
  int cur_p = 0, p1 = 0, p2 = 0, p3 = 0;
  int exp_addr = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_run = 0; cur_p = 0;
      run1 = 0; run2 = 0; run3 = 0;
      p1 = 0; p2 = 0; p3 = 0;
      exp_addr = 0;
    end else begin
      if (in_win(cur_run, cur_p)) exp_addr = win_addr(cur_p);
      run3 = run2; p3 = p2;
      run2 = run1; p2 = p1;
      run1 = cur_run; p1 = cur_p;
      if (!cur_run) begin
        if (en) begin cur_run = 1; cur_p = 0; end
      end else if (cur_p == FRAME - 1) begin
        cur_p = 0;
        cur_run = en;
      end else begin
        cur_p++;
      end
    end
  end

  int max_addr = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      int h, v;
      bit e_de, e_hs, e_vs, e_win, e_fs;
      logic [23:0] e_rgb;
      h = p3 % HT;
      v = p3 / HT;
      e_de  = run3 && h < HA && v < VA;
      e_hs  = !(run3 && h >= HA + HF && h < HA + HF + HS);
      e_vs  = !(run3 && v >= VA + VF && v < VA + VF + VS);
      e_win = in_win(run3, p3);
      e_fs  = run3 && p3 == 0;
      e_rgb = e_win ? 24'(win_addr(p3)) : (e_de ? TBORDER : 24'h0);
      chk("rd_addr", rd_addr, exp_addr);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("de", de, e_de);
      chk("rgb", rgb, e_rgb);
      chk("frame_start", frame_start, e_fs);
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (run1 && p1 == TYO * HT + TXO) chk("pin_first_addr", rd_addr, 0);
      if (run1 && p1 == TYO * HT + TXO + TW - 1) chk("pin_line0_end", rd_addr, 24);
      if (run1 && p1 == (TYO + 1) * HT + TXO) chk("pin_line1_start", rd_addr, 25);
      if (run1 && p1 == (TYO + TH - 1) * HT + TXO + TW - 1) chk("pin_last_addr", rd_addr, 274);
      if (run3 && p3 == 10 * HT + 10) begin
        chk("pin_border_de", de, 1);
        chk("pin_border_rgb", rgb, 24'h123456);
      end
      if (run3 && p3 == 5 * HT + 70) begin
        chk("pin_blank_de", de, 0);
        chk("pin_blank_rgb", rgb, 0);
      end
    end
  end

  logic [43:0] cap [FRAME];

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask

  initial begin
    int idle_bad, fs_at, fs_n, hs_lo, vs_lo, de_n, rep_bad;
    rstn = 1'b0;
    en   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rstn   = 1'b1;
    chk_on = 1;

    idle_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (de || !hsync || !vsync || rgb != 0 || rd_addr != 0 || frame_start) idle_bad++;
    end
    chk("idle_quiet", idle_bad, 0);

    en = 1'b1;
    fs_at = -1; fs_n = 0; hs_lo = 0; vs_lo = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      cap[i] = {rd_addr, rgb, hsync, vsync, de, frame_start};
      if (frame_start) begin
        fs_n++;
        if (fs_at < 0) fs_at = i;
      end
      if (!hsync) hs_lo++;
      if (!vsync) vs_lo++;
    end
    chk("fs_latency", fs_at, 3);
    chk("fs_count_frame1", fs_n, 1);
    chk("hsync_low_cycles", hs_lo, 384);
    chk("vsync_low_cycles", vs_lo, 160);

    repeat (30 * HT) @(negedge clk);
    en = 1'b0;
    de_n = 0; fs_n = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      de_n += int'(de);
      fs_n += int'(frame_start);
    end
    chk("drain_de_count", de_n, 640);
    chk("no_restart", fs_n, 0);
    chk("idle_addr_hold", rd_addr, 274);
    chk("idle_hsync", hsync, 1);
    chk("idle_vsync", vsync, 1);

    en = 1'b1;
    repeat (20 * HT + 30) @(negedge clk);
    chk("pre_reset_de", de, 1);
    #2 rstn = 1'b0;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    rstn = 1'b1;
    rep_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if ({rd_addr, rgb, hsync, vsync, de, frame_start} !== cap[i]) rep_bad++;
    end
    chk("frame_repeat", rep_bad, 0);
    chk("addr_max", max_addr, 274);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/frame_scan_reader.md
# frame_scan_reader

Display-side scan reader for the processed image. It sits directly downstream of the Laplacian convolution stage, which holds a 250×114 8-bit result frame with a registered 24-bit (grey replicated) read port. The block generates VGA 640×480 timing and drives the result-memory read address in raster order. It places the image window inside the active area and outputs pipeline-aligned sync, data-enable and RGB for the display interface.

## Interface
Parameters:
- IMG_W, 250, image width in pixels
- IMG_H, 114, image height in lines
- ADDR_W, 15, result-memory address width
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing (H_TOTAL = 800)
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing (V_TOTAL = 525)
- X_OFF, 195, first active column of the image window
- Y_OFF, 183, first active line of the image window
- BORDER, 24'h000000, RGB driven inside the active area but outside the window

Ports:
- clk  in  1  system clock; single clock domain
- rstn  in  1  asynchronous active-low reset
- en  in  1  scan enable; sampled only at frame boundaries
- rd_addr  out  ADDR_W  result-memory read address; registered
- rd_data  in  24  result-memory read data; valid one cycle after rd_addr
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  active-video data enable
- rgb  out  24  pixel output; 0 when de = 0
- frame_start  out  1  one-cycle pulse, aligned with the output of pixel (0,0)

## Operation
- Counters h (0..799) and v (0..524).
  - h wraps to 0 at 799 and increments v.
  - v wraps to 0 at 524.
- Active area: h < 640 and v < 480.
- hsync is low for h in [656, 752).
- vsync is low for v in [490, 492).
- Window: h in [X_OFF, X_OFF+IMG_W) and v in [Y_OFF, Y_OFF+IMG_H).
- Address generation is incremental; no multiplier.
  - Line base resets to 0 at v = 0.
  - Line base advances by IMG_W at the end of each in-window line.
  - Column offset is 0 at h = X_OFF and increments across the window.
- rd_addr = line_base + col while in the window. Outside the window rd_addr holds its last value.
- Output selection:
  - window: rgb = rd_data
  - active area, outside window: rgb = BORDER
  - blanking: rgb = 0
- Enable/idle behaviour:
  - Idle state (en low at a frame boundary, or after reset): counters held at 0, hsync = vsync = 1, de = 0, rgb = 0, no frame_start.
  - Scanning begins at (0,0) on the cycle after en is sampled high while idle.
  - At the wrap (h=799, v=524), en low means go idle; en high means continue.
  - en falling mid-frame has no effect until that frame completes.

## Timing
- Pipeline latency: 3 cycles from counter state to outputs.
  - t: counters hold (h, v).
  - t+1: rd_addr registered.
  - t+2: rd_data valid.
  - t+3: hsync, vsync, de, rgb and frame_start registered.
- Sync, de and frame_start are delayed by matching registers so that all outputs stay aligned.
- Reset values: rd_addr = 0, hsync = 1, vsync = 1, de = 0, rgb = 0, frame_start = 0. All pipeline registers clear.
- Reset asserted mid-frame returns the block to idle immediately. The pipeline is flushed; no partial pixels follow.
- Address boundaries:
  - First window pixel (h=195, v=183): rd_addr = 0.
  - Last window pixel (h=444, v=296): rd_addr = 28499.
  - rd_addr never exceeds IMG_W*IMG_H-1.
- Going idle: the final 3 pipeline stages of the frame still drain to the outputs.

## Structure
- Shared package, used by the convolution stage and this block:
  - IMG_W, IMG_H, ADDR_W
  - VGA timing constants and the derived H_TOTAL/V_TOTAL
  - the pixel type as a 24-bit RGB typedef
- Sub-module video_timing: h/v counters, en/idle control, raw sync/active/window flags at stage t.
- frame_scan_reader instantiates video_timing and holds the address generator plus the 3-stage alignment pipeline.

## Test plan
- Reset, then en=0 for 1000 cycles -> hsync=vsync=1, de=0, rgb=0, rd_addr=0 throughout.
- en=1 after reset -> frame_start pulses 3 cycles after scan starts. The hsync low pulse is 96 cycles wide and occurs every 800 cycles. vsync is low for 1600 cycles per 420000-cycle frame.
- Memory model returns data = address -> addresses follow lines 0..113:
  - first window pixel: rd_addr 0
  - line 0 ends at 249; line 1 starts at 250
  - final pixel 28499
  - rgb matches the model, delayed exactly 2 cycles after rd_addr
- Active non-window pixel (h=10, v=10) -> de=1 and rgb=BORDER. Blanking pixel -> de=0 and rgb=0.
- en deasserted at v=300 -> frame completes normally, the block goes idle at the wrap, no second frame_start. Re-asserting en restarts at (0,0) with rd_addr 0 on the first window pixel.
- rstn pulsed low at v=250, h=300 -> all outputs take reset values within the same cycle. After release with en=1, the next frame is bit-identical to a frame scanned from a clean reset.
